// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the CPU instruction memory.
// Takes a byte stream over a valid/ready handshake and packs byte pairs into
// 16-bit words, high byte first. Each word is written to the next
// instruction-memory address, starting at 0. The halt word 16'hFFFF is
// written as well, then the loader stops and raises cpu_run.
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the terminator before cpu_run is released.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      source presents a byte on in_data
//   in_data       stream byte
//   in_ready      loader can accept a byte this cycle
//   imem_we       one-cycle instruction-memory write strobe
//   imem_addr     write address in words (registered)
//   imem_wdata    instruction word to write (registered)
//   loading       high while the program is being received or written
//   cpu_run       program loaded, CPU may fetch (sticky until reset)
//   error         load failed (sticky until reset)
//   word_count    words written so far, including the terminator
module imem_loader #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        loading,
    output logic        cpu_run,
    output logic        error,
    output logic [15:0] word_count
);

    localparam logic [15:0] LAST_ADDR = 16'(MAX_WORDS - 1);
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        S_RECV_HI,
        S_RECV_LO,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_next;
    logic [15:0] addr;
    logic [15:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        loading    = 1'b0;
        cpu_run    = 1'b0;
        error      = 1'b0;
        case (state)
            S_RECV_HI: begin
                in_ready = 1'b1;
                loading  = 1'b1;
                if (in_valid) state_next = S_RECV_LO;
            end
            S_RECV_LO: begin
                in_ready = 1'b1;
                loading  = 1'b1;
                if (in_valid) state_next = S_WRITE;
            end
            S_WRITE: begin
                imem_we = 1'b1;
                loading = 1'b1;
                // Terminator check takes priority over the capacity check,
                // so a terminator landing in the last slot still succeeds.
                if (word == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CHK;
`else
                    state_next = S_DONE;
`endif
                end else if (addr == LAST_ADDR) begin
                    state_next = S_ERROR;
                end else begin
                    state_next = S_RECV_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                loading  = 1'b1;
                if (in_valid) state_next = (in_data == checksum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                cpu_run = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_next = S_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RECV_HI;
            addr       <= '0;
            word       <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_RECV_HI: begin
                    if (in_valid) word[15:8] <= in_data;
                end
                S_RECV_LO: begin
                    // Output registers are loaded here so they are already
                    // valid during the WRITE cycle and hold afterwards.
                    if (in_valid) begin
                        word[7:0]  <= in_data;
                        imem_wdata <= {word[15:8], in_data};
                        imem_addr  <= addr;
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + 16'd1;
                    if (word != HALT_WORD && addr != LAST_ADDR) addr <= addr + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of every byte accepted in the receive states, which
    // includes both terminator bytes; the check byte itself is excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (in_valid && (state == S_RECV_HI || state == S_RECV_LO)) begin
            checksum <= checksum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader (MAX_WORDS = 4).
// A stream-level reference model turns a byte list into the expected write
// list and final outcome; a monitor records every write strobe.
module tb_imem_loader;

    localparam int unsigned MAXW = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        loading;
    logic        cpu_run;
    logic        error;
    logic [15:0] word_count;

    imem_loader #(.MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .loading    (loading),
        .cpu_run    (cpu_run),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int timeouts = 0;
    int unsigned gap_max = 0;

    logic [31:0] cap[$];
    logic [31:0] exp_w[$];
    int          exp_outcome;   // 0 still loading, 1 done, 2 error
    int unsigned exp_consumed;
    logic [7:0]  bs[$];

    // Write monitor: every strobe cycle is recorded; a strobe with ready high is a violation.
    always @(negedge clk) begin
        if (imem_we) begin
            cap.push_back({imem_addr, imem_wdata});
            if (in_ready) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, expv);
        end
    endtask

    // Reference model: walk the stream in byte pairs.
    task automatic run_model(input logic [7:0] s[$]);
        int unsigned idx  = 0;
        int unsigned a    = 0;
        logic [7:0]  cs   = 8'h00;
        logic [15:0] w;
        bit          stop = 0;
        exp_w.delete();
        exp_outcome = 0;
        while (!stop && exp_outcome == 0 && idx + 1 < s.size()) begin
            w = {s[idx], s[idx+1]};
            cs = cs ^ s[idx] ^ s[idx+1];
            idx += 2;
            exp_w.push_back({a[15:0], w});
            if (w == 16'hFFFF) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (idx < s.size()) begin
                    exp_outcome = (s[idx] == cs) ? 1 : 2;
                    idx++;
                end else begin
                    stop = 1;
                end
`else
                exp_outcome = 1;
`endif
            end else if (a == MAXW - 1) begin
                exp_outcome = 2;
            end else begin
                a++;
            end
        end
        exp_consumed = idx;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned gap;
        int unsigned g = 0;
        gap = (gap_max != 0) ? $urandom_range(0, gap_max) : 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) timeouts++;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int unsigned cnt);
        for (int unsigned i = 0; i < cnt; i++) send_byte(s[i]);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check({tag, ".rst_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".rst_we"}, 32'(imem_we), 32'd0);
        check({tag, ".rst_addr"}, 32'(imem_addr), 32'd0);
        check({tag, ".rst_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, ".rst_loading"}, 32'(loading), 32'd1);
        check({tag, ".rst_cpu_run"}, 32'(cpu_run), 32'd0);
        check({tag, ".rst_error"}, 32'(error), 32'd0);
        check({tag, ".rst_word_count"}, 32'(word_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cap.delete();
    endtask

    task automatic verify(input string tag);
        repeat (4) @(negedge clk);
        check({tag, ".nwrites"}, 32'(cap.size()), 32'(exp_w.size()));
        for (int unsigned i = 0; i < exp_w.size(); i++)
            check($sformatf("%s.write%0d", tag, i), (i < cap.size()) ? cap[i] : 32'hDEAD_BEEF, exp_w[i]);
        check({tag, ".word_count"}, 32'(word_count), 32'(exp_w.size()));
        check({tag, ".cpu_run"}, 32'(cpu_run), 32'(exp_outcome == 1));
        check({tag, ".error"}, 32'(error), 32'(exp_outcome == 2));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_outcome == 0));
        check({tag, ".loading"}, 32'(loading), 32'(exp_outcome == 0));
        check({tag, ".ready_in_write"}, 32'(viol), 32'd0);
        check({tag, ".timeouts"}, 32'(timeouts), 32'd0);
    endtask

    task automatic run_stream(input string tag);
        run_model(bs);
        send_stream(bs, exp_consumed);
        verify(tag);
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  x;
        int unsigned n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2;
        check("init.in_ready", 32'(in_ready), 32'd1);
        check("init.word_count", 32'(word_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic load, no gaps.
        do_reset("basic");
        gap_max = 0;
        bs = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        bs.push_back(8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD);
`endif
        run_stream("basic");
        check("basic.w0", cap[0], 32'h0000_1234);
        check("basic.w1", cap[1], 32'h0001_ABCD);
        check("basic.w2", cap[2], 32'h0002_FFFF);
        check("basic.run", 32'(cpu_run), 32'd1);

        // Same stream under random gaps.
        do_reset("gaps");
        gap_max = 3;
        run_stream("gaps");

        // Overflow: four non-terminator words fill MAX_WORDS = 4.
        do_reset("ovf");
        bs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_stream("ovf");
        check("ovf.error", 32'(error), 32'd1);
        check("ovf.w3", cap[3], 32'h0003_0708);

        // Terminator in the last slot still succeeds.
        do_reset("lastslot");
        bs = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'hFF, 8'hFF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        bs.push_back(8'h00);
`endif
        run_stream("lastslot");

        // Reset mid-word: partial byte is dropped, no strobe, restart at 0.
        do_reset("midrst");
        gap_max = 0;
        send_byte(8'h56);
        do_reset("midrst2");
        check("midrst.nostrobe", 32'(cap.size()), 32'd0);
        bs = '{8'h00, 8'h01, 8'hFF, 8'hFF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        bs.push_back(8'h01);
`endif
        run_stream("midrst");
        check("midrst.w0", cap[0], 32'h0000_0001);

        // Lone FF byte is not a terminator.
        do_reset("loneff");
        bs = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        bs.push_back(8'hFF);
`endif
        run_stream("loneff");
        check("loneff.w0", cap[0], 32'h0000_FF00);
        check("loneff.wc", 32'(word_count), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset("cs_ok");
        bs = '{8'h12, 8'h34, 8'hFF, 8'hFF, 8'h26};
        run_stream("cs_ok");
        check("cs_ok.run", 32'(cpu_run), 32'd1);
        do_reset("cs_bad");
        bs = '{8'h12, 8'h34, 8'hFF, 8'hFF, 8'h27};
        run_stream("cs_bad");
        check("cs_bad.error", 32'(error), 32'd1);
`endif

        // Randomized programs with random gaps.
        gap_max = 2;
        for (int t = 0; t < 20; t++) begin
            do_reset("rnd");
            bs.delete();
            x = 8'h00;
            n = $urandom_range(0, 5);
            for (int unsigned i = 0; i < n; i++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 3) == 0) w[15:8] = 8'hFF;
                if (w == 16'hFFFF) w = 16'hFFFE;
                bs.push_back(w[15:8]);
                bs.push_back(w[7:0]);
                x = x ^ w[15:8] ^ w[7:0];
            end
            bs.push_back(8'hFF);
            bs.push_back(8'hFF);
`ifdef IMEM_LOADER_CHECKSUM_EN
            bs.push_back(($urandom_range(0, 2) == 0) ? (x ^ 8'h01) : x);
`endif
            run_stream($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
